hazard_controller: RTL and testbench

Pipeline sequencing unit for the 5-stage core (IF, ID, EX, MEM, WB). It replaces fixed per-stage write enables with hazard-driven ones:
- RAW stalls from an in-flight destination scoreboard.
- Fetch hold and wrong-path squash for control-flow instructions until they redirect the PC at WB.
- Whole-pipeline freeze while RAM has not acknowledged a MEM-stage access.

It sits beside the pipeline registers and drives their write-enable and bubble inputs.

---
 rtl/hazard_controller_pkg.sv | 48 ++++
 rtl/hazard_controller_if.sv | 41 ++++
 rtl/hazard_controller_scoreboard.sv | 55 +++++
 rtl/hazard_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_controller.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, PC source
// selects, the pipeline-control bundle and its hold/run values.
package hazard_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_CTRL_WAIT = 2'd1,
    ST_MEM_WAIT  = 2'd2
  } hc_state_e;

  localparam logic       PC_SRC_SEQ     = 1'b0;
  localparam logic       PC_SRC_WB      = 1'b1;
  localparam logic [1:0] CTRL_CNT_ISSUE = 2'd2;
  localparam logic [4:0] REG_ZERO       = 5'd0;

  typedef struct packed {
    logic pc_wren;
    logic pc_src;
    logic if_id_wren;
    logic id_ex_wren;
    logic ex_mem_wren;
    logic mem_wb_wren;
    logic if_id_bubble;
    logic id_ex_bubble;
    logic reg_wren;
  } pipe_ctrl_t;

  // Everything held, no NOP injection: used while frozen or in reset.
  localparam pipe_ctrl_t PIPE_CTRL_HOLD = '{default: 1'b0};

  localparam pipe_ctrl_t PIPE_CTRL_RUN = '{
    pc_wren:      1'b1,
    pc_src:       PC_SRC_SEQ,
    if_id_wren:   1'b1,
    id_ex_wren:   1'b1,
    ex_mem_wren:  1'b1,
    mem_wb_wren:  1'b1,
    if_id_bubble: 1'b0,
    id_ex_bubble: 1'b0,
    reg_wren:     1'b1
  };

  function automatic logic src_hits(input logic used, input logic [4:0] rs,
                                    input logic valid, input logic [4:0] rd);
    return used && (rs != REG_ZERO) && valid && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side signals of the hazard controller: ID operands, MEM/RAM
// handshake and the pipeline-register control strobes.
interface hazard_controller_if;
  logic [4:0] id_rs1_address;
  logic [4:0] id_rs2_address;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [4:0] id_rd_address;
  logic       id_reg_wren;
  logic       id_is_control;
  logic       mem_ram_access;
  logic       mem_ram_write;
  logic       ram_ready;
  logic       pc_wren;
  logic       pc_src;
  logic       if_id_wren;
  logic       id_ex_wren;
  logic       ex_mem_wren;
  logic       mem_wb_wren;
  logic       if_id_bubble;
  logic       id_ex_bubble;
  logic       ram_req;
  logic       ram_wren;
  logic       reg_wren;

  modport master (
    input  id_rs1_address, id_rs2_address, id_rs1_used, id_rs2_used,
           id_rd_address, id_reg_wren, id_is_control,
           mem_ram_access, mem_ram_write, ram_ready,
    output pc_wren, pc_src, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
           if_id_bubble, id_ex_bubble, ram_req, ram_wren, reg_wren
  );

  modport slave (
    output id_rs1_address, id_rs2_address, id_rs1_used, id_rs2_used,
           id_rd_address, id_reg_wren, id_is_control,
           mem_ram_access, mem_ram_write, ram_ready,
    input  pc_wren, pc_src, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
           if_id_bubble, id_ex_bubble, ram_req, ram_wren, reg_wren
  );
endinterface

// File: rtl/hazard_controller_scoreboard.sv
// In-flight destination scoreboard for EX/MEM/WB (index 0/1/2) and the RAW
// compare against the sources of the instruction in ID.
module hazard_scoreboard
  import hazard_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       advance,
  input  logic       ex_valid_in,
  input  logic [4:0] ex_rd_in,
  input  logic [4:0] rs1_address,
  input  logic [4:0] rs2_address,
  input  logic       rs1_used,
  input  logic       rs2_used,
  output logic       raw_hazard
);

  logic [2:0]      sb_valid_q, sb_valid_d;
  logic [2:0][4:0] sb_rd_q, sb_rd_d;

  // Shift one stage per advancing cycle; a freeze holds every entry.
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_rd_d    = sb_rd_q;
    if (advance) begin
      sb_valid_d = {sb_valid_q[1:0], ex_valid_in};
      sb_rd_d    = {sb_rd_q[1:0], ex_rd_in};
    end else begin
      sb_valid_d = sb_valid_q;
      sb_rd_d    = sb_rd_q;
    end
  end

  // Scoreboard registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_valid_q <= 3'b000;
      sb_rd_q    <= {3{5'd0}};
    end else begin
      sb_valid_q <= sb_valid_d;
      sb_rd_q    <= sb_rd_d;
    end
  end

  // WB is compared too: the register file has no write-through.
  always_comb begin
    raw_hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      raw_hazard = raw_hazard
                 | src_hits(rs1_used, rs1_address, sb_valid_q[i], sb_rd_q[i])
                 | src_hits(rs2_used, rs2_address, sb_valid_q[i], sb_rd_q[i]);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Hazard-driven pipeline sequencer: RAW stalls, control-flow fetch hold and
// squash, and whole-pipeline freeze on unacknowledged RAM accesses.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  hazard_controller_if.master        bus,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_MAX = {STALL_CNT_WIDTH{1'b1}};
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

  hc_state_e                  state_q, state_d, saved_q, saved_d, eff_state_s;
  logic [1:0]                 ctrl_cnt_q, ctrl_cnt_d;
  logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;
  logic                       freeze_s, raw_s, issue_s, ex_valid_s;
  pipe_ctrl_t                 ctrl_s;

  assign freeze_s    = bus.mem_ram_access && !bus.ram_ready;
  // On release, MEM_WAIT behaves exactly like the state it interrupted.
  assign eff_state_s = (state_q == ST_MEM_WAIT) ? saved_q : state_q;
  assign ex_valid_s  = issue_s && bus.id_reg_wren && (bus.id_rd_address != REG_ZERO);

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .reset_n     (reset_n),
    .advance     (!freeze_s),
    .ex_valid_in (ex_valid_s),
    .ex_rd_in    (bus.id_rd_address),
    .rs1_address (bus.id_rs1_address),
    .rs2_address (bus.id_rs2_address),
    .rs1_used    (bus.id_rs1_used),
    .rs2_used    (bus.id_rs2_used),
    .raw_hazard  (raw_s)
  );

  // State, saved state, control countdown and stall counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      saved_q    <= ST_RUN;
      ctrl_cnt_q <= 2'd0;
      stall_q    <= {STALL_CNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      ctrl_cnt_q <= ctrl_cnt_d;
      stall_q    <= stall_d;
    end
  end

  // Next-state logic; freeze wins over RAW and control decisions.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    ctrl_cnt_d = ctrl_cnt_q;
    if (freeze_s) begin
      state_d = ST_MEM_WAIT;
      saved_d = eff_state_s;
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          if (!raw_s && bus.id_is_control) begin
            state_d    = ST_CTRL_WAIT;
            ctrl_cnt_d = CTRL_CNT_ISSUE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_CTRL_WAIT: begin
          if (ctrl_cnt_q == 2'd0) begin
            state_d = ST_RUN;
          end else begin
            state_d    = ST_CTRL_WAIT;
            ctrl_cnt_d = ctrl_cnt_q - 2'd1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Pipeline control outputs for the effective state.
  always_comb begin
    ctrl_s  = PIPE_CTRL_HOLD;
    issue_s = 1'b0;
    if (!reset_n || freeze_s) begin
      ctrl_s = PIPE_CTRL_HOLD;
    end else begin
      case (eff_state_s)
        ST_RUN: begin
          ctrl_s = PIPE_CTRL_RUN;
          if (raw_s) begin
            ctrl_s.pc_wren      = 1'b0;
            ctrl_s.if_id_wren   = 1'b0;
            ctrl_s.id_ex_bubble = 1'b1;
          end else if (bus.id_is_control) begin
            issue_s             = 1'b1;
            ctrl_s.pc_wren      = 1'b0;
            ctrl_s.if_id_bubble = 1'b1;
          end else begin
            issue_s = 1'b1;
          end
        end
        ST_CTRL_WAIT: begin
          ctrl_s              = PIPE_CTRL_RUN;
          ctrl_s.if_id_bubble = 1'b1;
          ctrl_s.id_ex_bubble = 1'b1;
          ctrl_s.pc_wren      = (ctrl_cnt_q == 2'd0);
          ctrl_s.pc_src       = (ctrl_cnt_q == 2'd0) ? PC_SRC_WB : PC_SRC_SEQ;
        end
        default: ctrl_s = PIPE_CTRL_HOLD;
      endcase
    end
  end

  // Saturating count of cycles in which the PC does not load.
  always_comb begin
    if (!ctrl_s.pc_wren && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + STALL_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  assign bus.pc_wren      = ctrl_s.pc_wren;
  assign bus.pc_src       = ctrl_s.pc_src;
  assign bus.if_id_wren   = ctrl_s.if_id_wren;
  assign bus.id_ex_wren   = ctrl_s.id_ex_wren;
  assign bus.ex_mem_wren  = ctrl_s.ex_mem_wren;
  assign bus.mem_wb_wren  = ctrl_s.mem_wb_wren;
  assign bus.if_id_bubble = ctrl_s.if_id_bubble;
  assign bus.id_ex_bubble = ctrl_s.id_ex_bubble;
  assign bus.reg_wren     = ctrl_s.reg_wren;
  assign bus.ram_req      = reset_n && bus.mem_ram_access;
  assign bus.ram_wren     = bus.ram_req && bus.ram_ready && bus.mem_ram_write;
  assign stall_cycles     = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed plus random bench for hazard_controller against an occupancy model
// that tracks which destinations and which control instruction sit in EX/MEM/WB.
module tb_hazard_controller;

  localparam int W = 4;
  localparam int SAT = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] stall_cycles;
  int           total = 0;
  int           bad = 0;

  int m_rd[3];
  int m_ctrl;
  int m_stall;

  hazard_controller_if bus ();

  hazard_controller #(.STALL_CNT_WIDTH(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {bus.pc_wren, bus.pc_src, bus.if_id_wren, bus.id_ex_wren, bus.ex_mem_wren,
            bus.mem_wb_wren, bus.if_id_bubble, bus.id_ex_bubble, bus.ram_req,
            bus.ram_wren, bus.reg_wren};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_rd[i] = 0;
    m_ctrl  = -1;
    m_stall = 0;
  endtask

  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic rdw,
                       input logic ctl, input logic acc, input logic mwr, input logic rdy);
    bus.id_rs1_address = rs1;
    bus.id_rs2_address = rs2;
    bus.id_rs1_used    = u1;
    bus.id_rs2_used    = u2;
    bus.id_rd_address  = rd;
    bus.id_reg_wren    = rdw;
    bus.id_is_control  = ctl;
    bus.mem_ram_access = acc;
    bus.mem_ram_write  = mwr;
    bus.ram_ready      = rdy;
  endtask

  // One pipeline cycle: drive, check against the model, advance the model.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic rdw,
                      input logic ctl, input logic acc, input logic mwr, input logic rdy);
    logic        frozen, haz, pcw, pcs, ifw, ifb, idb;
    logic [10:0] exp;
    int          new_rd;
    drive(rs1, rs2, u1, u2, rd, rdw, ctl, acc, mwr, rdy);
    #2;
    frozen = acc && !rdy;
    haz    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (u1 && rs1 != 5'd0 && int'(rs1) == m_rd[i]) haz = 1'b1;
      if (u2 && rs2 != 5'd0 && int'(rs2) == m_rd[i]) haz = 1'b1;
    end
    new_rd = 0;
    pcw = 1'b1; pcs = 1'b0; ifw = 1'b1; ifb = 1'b0; idb = 1'b0;
    if (frozen) begin
      pcw = 1'b0; ifw = 1'b0;
    end else if (m_ctrl >= 0) begin
      ifb = 1'b1; idb = 1'b1;
      pcw = (m_ctrl == 2);
      pcs = (m_ctrl == 2);
    end else if (haz) begin
      pcw = 1'b0; ifw = 1'b0; idb = 1'b1;
    end else begin
      new_rd = rdw ? int'(rd) : 0;
      if (ctl) begin
        pcw = 1'b0; ifb = 1'b1;
      end
    end
    exp = {pcw, pcs, ifw, {3{!frozen}}, ifb, idb, acc, acc && rdy && mwr, !frozen};
    check("outputs", 32'(outs()), 32'(exp));
    check("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    if (!pcw && m_stall < SAT) m_stall++;
    if (!frozen) begin
      m_rd[2] = m_rd[1];
      m_rd[1] = m_rd[0];
      m_rd[0] = new_rd;
      if (m_ctrl == 2) m_ctrl = -1;
      else if (m_ctrl >= 0) m_ctrl++;
      else if (!haz && ctl) m_ctrl = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Asynchronous reset mid-cycle with a pending store on the bus.
  task automatic do_reset();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0;
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    #2;
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_stall", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // add x5 ; add x6,x5 (held in ID through three stalls)
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      step(5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("raw_stall_count", 32'(stall_cycles), 32'd3);

    // write x0 then read x0: no stall
    do_reset();
    step(5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("x0_no_stall", 32'(stall_cycles), 32'd0);

    // taken beq followed by wrong-path slots
    step(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) nop();

    // store waiting four cycles for RAM
    for (int i = 0; i < 4; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    nop();

    // jal issued, then a load stalls while it is in flight
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) nop();

    // reset during CTRL_WAIT, then during MEM_WAIT
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    nop();
    do_reset();
    step(5'd3, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd2, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    do_reset();
    step(5'd2, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // random traffic with occasional resets
    for (int n = 0; n < 800; n++) begin
      if (n % 150 == 149) do_reset();
      else step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                1'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
